// File: rtl/parity_serial_tx.sv
// Parity-framing serial transmitter: start, 8 data bits LSB-first, parity, stop.
// The {parity_bit, data} pair forms the 9-bit word checked on the receive side.
module parity_serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit ODD_PARITY   = 1'b0
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       enable,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       parity_bit,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

  state_t     state;
  logic [7:0] bit_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic       bit_end;

  assign bit_end = (bit_cnt == LAST);

  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      parity_bit <= 1'b0;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
    end else begin
      // done is a strict one-cycle pulse, so it drops even while stalled
      done <= 1'b0;
      if (enable) begin
        if (state != IDLE) bit_cnt <= bit_end ? 8'd0 : bit_cnt + 8'd1;
        case (state)
          IDLE: begin
            tx <= 1'b1;
            if (start) begin
              shift      <= data_in;
              parity_bit <= (^data_in) ^ ODD_PARITY;
              busy       <= 1'b1;
              tx         <= 1'b0;
              bit_cnt    <= '0;
              bit_idx    <= '0;
              state      <= START;
            end
          end
          START: if (bit_end) begin
            state <= DATA;
            tx    <= shift[0];
          end
          DATA: if (bit_end) begin
            shift <= shift >> 1;
            if (bit_idx == 3'd7) begin
              state <= PARITY;
              tx    <= parity_bit;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end
          PARITY: if (bit_end) begin
            state <= STOP;
            tx    <= 1'b1;
          end
          STOP: if (bit_end) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Scoreboard bench for parity_serial_tx: even and odd instances share stimulus;
// a negedge monitor rebuilds each frame from tx and checks it against queued bytes.
module tb_parity_serial_tx;

  localparam int C     = 4;
  localparam int FRAME = 11 * C;

  logic       clk = 1'b0;
  logic       clear, enable, start;
  logic [7:0] data_in;
  logic       tx_e, pb_e, busy_e, done_e;
  logic       tx_o, pb_o, busy_o, done_o;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] qe[$];
  logic [7:0] qo[$];
  int         ns [2];
  logic       samp [2][FRAME];

  always #5 clk = ~clk;

  parity_serial_tx #(.CLKS_PER_BIT(C), .ODD_PARITY(1'b0)) u_even (
    .clk(clk), .clear(clear), .enable(enable), .start(start), .data_in(data_in),
    .tx(tx_e), .parity_bit(pb_e), .busy(busy_e), .done(done_e));

  parity_serial_tx #(.CLKS_PER_BIT(C), .ODD_PARITY(1'b1)) u_odd (
    .clk(clk), .clear(clear), .enable(enable), .start(start), .data_in(data_in),
    .tx(tx_o), .parity_bit(pb_o), .busy(busy_o), .done(done_o));

  // Rebuild one instance's frame from enabled busy cycles and score it on done
  task automatic mon(input int m, input logic t, input logic b, input logic d, input logic pb);
    logic [10:0] bits;
    logic        stable;
    logic [7:0]  exp_d;
    logic        exp_p;
    int          ones;
    if (b && enable) begin
      if (ns[m] < FRAME) samp[m][ns[m]] = t;
      ns[m]++;
    end
    if (d) begin
      n_checks++;
      if (ns[m] != FRAME) begin
        n_fail++;
        $display("FAIL frame_len[%0d]: got %0d enabled cycles, want %0d", m, ns[m], FRAME);
      end else begin
        stable = 1'b1;
        for (int k = 0; k < 11; k++) begin
          bits[k] = samp[m][k*C];
          for (int j = 1; j < C; j++) if (samp[m][k*C+j] !== bits[k]) stable = 1'b0;
        end
        n_checks++;
        if (!stable) begin n_fail++; $display("FAIL bit_stable[%0d]: tx moved inside a bit, got %b want 1", m, stable); end
        n_checks++;
        if ((m == 0 && qe.size() == 0) || (m == 1 && qo.size() == 0)) begin
          n_fail++;
          $display("FAIL scoreboard[%0d]: frame with no queued byte, got 0 entries want 1", m);
        end else begin
          if (m == 0) exp_d = qe.pop_front();
          else        exp_d = qo.pop_front();
          exp_p = (^exp_d) ^ m[0];
          ones  = $countones({bits[9], bits[8:1]});
          n_checks++;
          if (bits[0] !== 1'b0) begin n_fail++; $display("FAIL start_bit[%0d]: got %b want 0", m, bits[0]); end
          n_checks++;
          if (bits[8:1] !== exp_d) begin n_fail++; $display("FAIL data[%0d]: got %h want %h", m, bits[8:1], exp_d); end
          n_checks++;
          if (bits[9] !== exp_p) begin n_fail++; $display("FAIL parity_tx[%0d] data %h: got %b want %b", m, exp_d, bits[9], exp_p); end
          n_checks++;
          if (bits[10] !== 1'b1) begin n_fail++; $display("FAIL stop_bit[%0d]: got %b want 1", m, bits[10]); end
          n_checks++;
          if (pb !== exp_p) begin n_fail++; $display("FAIL parity_out[%0d] data %h: got %b want %b", m, exp_d, pb, exp_p); end
          n_checks++;
          if (m == 0 && (ones % 2) != 0) begin n_fail++; $display("FAIL hc280_pe data %h: got pe=0 want pe=1", exp_d); end
          if (m == 1 && (ones % 2) != 1) begin n_fail++; $display("FAIL hc280_po data %h: got po=0 want po=1", exp_d); end
        end
      end
      ns[m] = 0;
    end else if (!b && ns[m] != 0) begin
      ns[m] = 0;
    end
  endtask

  always @(negedge clk) begin
    mon(0, tx_e, busy_e, done_e, pb_e);
    mon(1, tx_o, busy_o, done_o, pb_o);
  end

  task automatic send(input logic [7:0] d);
    start = 1'b1; data_in = d;
    @(posedge clk); #1;
    start = 1'b0;
    qe.push_back(d); qo.push_back(d);
  endtask

  task automatic wait_done(input int budget, output int bc, output bit ok);
    bc = 0; ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (busy_e) bc++;
      if (done_e) ok = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk); #1;
    n_checks++; if (tx_e !== 1'b1)   begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx_e); end
    n_checks++; if (busy_e !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_e); end
    n_checks++; if (done_e !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_e); end
    n_checks++; if (pb_o !== 1'b0)   begin n_fail++; $display("FAIL reset_parity: got %b want 0", pb_o); end
    clear = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (tx_e !== 1'b1)   begin n_fail++; $display("FAIL idle_tx: got %b want 1", tx_e); end
  endtask

  task automatic test_frame_a5;
    int bc; bit ok;
    send(8'hA5);
    n_checks++; if (tx_e !== 1'b0) begin n_fail++; $display("FAIL a5_first_tx: got %b want 0", tx_e); end
    wait_done(200, bc, ok);
    n_checks++; if (!ok)     begin n_fail++; $display("FAIL a5_done: got timeout want done pulse"); end
    n_checks++; if (bc != 44) begin n_fail++; $display("FAIL a5_busy_len: got %0d want 44", bc); end
    @(negedge clk);
    n_checks++; if (done_e !== 1'b0) begin n_fail++; $display("FAIL a5_done_width: got %b want 0", done_e); end
    @(posedge clk); #1;
  endtask

  task automatic test_parity_cases;
    int bc; bit ok;
    send(8'h07);
    n_checks++; if (pb_e !== 1'b1) begin n_fail++; $display("FAIL p07_even: got %b want 1", pb_e); end
    n_checks++; if (pb_o !== 1'b0) begin n_fail++; $display("FAIL p07_odd: got %b want 0", pb_o); end
    wait_done(200, bc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL p07_done: got timeout want done pulse"); end
    send(8'h00);
    n_checks++; if (pb_e !== 1'b0) begin n_fail++; $display("FAIL p00_even: got %b want 0", pb_e); end
    wait_done(200, bc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL p00_done: got timeout want done pulse"); end
  endtask

  task automatic test_exhaustive;
    int bc; bit ok;
    for (int d = 0; d < 256; d++) begin
      send(8'(d));
      wait_done(100, bc, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL exh_done data %0d: got timeout want done pulse", d); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bb [4] = '{8'h81, 8'h7E, 8'h33, 8'hF0};
    int bc; bit ok; bit got;
    start = 1'b1; data_in = bb[0];
    @(posedge clk); #1;
    qe.push_back(bb[0]); qo.push_back(bb[0]);
    for (int i = 1; i < 4; i++) begin
      got = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
        @(negedge clk);
        if (done_e) begin
          data_in = bb[i];
          got = 1'b1;
          n_checks++; if (busy_e !== 1'b0) begin n_fail++; $display("FAIL b2b_idle[%0d]: got busy %b want 0", i, busy_e); end
        end else begin
          data_in = 8'($urandom);
        end
      end
      n_checks++; if (!got) begin n_fail++; $display("FAIL b2b_done[%0d]: got timeout want done pulse", i); end
      @(posedge clk); #1;
      qe.push_back(bb[i]); qo.push_back(bb[i]);
      n_checks++; if (busy_e !== 1'b1) begin n_fail++; $display("FAIL b2b_reaccept[%0d]: got busy %b want 1", i, busy_e); end
    end
    start = 1'b0;
    wait_done(200, bc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_last_done: got timeout want done pulse"); end
    repeat (5) begin
      @(negedge clk);
      n_checks++; if (busy_e !== 1'b0) begin n_fail++; $display("FAIL b2b_no_resend: got busy %b want 0", busy_e); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_clear_mid;
    int bc; bit ok;
    logic [7:0] junk;
    send(8'h3C);
    repeat (17) @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    n_checks++; if (tx_e !== 1'b1)   begin n_fail++; $display("FAIL clr_tx: got %b want 1", tx_e); end
    n_checks++; if (busy_e !== 1'b0) begin n_fail++; $display("FAIL clr_busy: got %b want 0", busy_e); end
    n_checks++; if (done_e !== 1'b0) begin n_fail++; $display("FAIL clr_done: got %b want 0", done_e); end
    n_checks++; if (pb_o !== 1'b0)   begin n_fail++; $display("FAIL clr_parity: got %b want 0", pb_o); end
    junk = qe.pop_back(); junk = qo.pop_back();
    repeat (5) begin
      @(negedge clk);
      n_checks++; if (done_e !== 1'b0) begin n_fail++; $display("FAIL clr_no_done: got %b want 0", done_e); end
    end
    @(posedge clk); #1;
    send(8'hC3);
    wait_done(200, bc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL clr_resend_done: got timeout want done pulse"); end
  endtask

  task automatic test_stall;
    int bc; bit ok;
    bc = 0; ok = 1'b0;
    send(8'h5A);
    for (int i = 0; i < 37; i++) begin
      @(negedge clk); if (busy_e) bc++;
      @(posedge clk); #1;
    end
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy_e) bc++;
      n_checks++; if (tx_e !== 1'b0)   begin n_fail++; $display("FAIL stall_tx_even: got %b want 0", tx_e); end
      n_checks++; if (tx_o !== 1'b1)   begin n_fail++; $display("FAIL stall_tx_odd: got %b want 1", tx_o); end
      n_checks++; if (done_e !== 1'b0) begin n_fail++; $display("FAIL stall_done: got %b want 0", done_e); end
      @(posedge clk); #1;
    end
    enable = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (busy_e) bc++;
      if (done_e) ok = 1'b1;
    end
    @(posedge clk); #1;
    n_checks++; if (!ok)      begin n_fail++; $display("FAIL stall_resume: got timeout want done pulse"); end
    n_checks++; if (bc != 54) begin n_fail++; $display("FAIL stall_busy_len: got %0d want 54", bc); end
  endtask

  initial begin
    clear = 1'b1; enable = 1'b1; start = 1'b0; data_in = 8'h00;
    ns[0] = 0; ns[1] = 0;
    test_reset();
    test_frame_a5();
    test_parity_cases();
    test_back_to_back();
    test_clear_mid();
    test_stall();
    test_exhaustive();
    n_checks++;
    if (qe.size() != 0 || qo.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d/%0d left want 0/0", qe.size(), qo.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before timeout");
    $fatal(1, "watchdog expired");
  end

endmodule
